// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer: hunts SYNC_BYTE and frames opcode/len/payload (+checksum when UART_CMD_CHECKSUM_EN) into a held command.
// Latency: cmd_valid_o rises the cycle after the final byte; err_o/err_code_o pulse the cycle after detection.
// Backpressure: command held until cmd_valid_o && cmd_ready_i; bytes arriving meanwhile are dropped with OVERRUN.

module uart_cmd_framer #(
    parameter int         MAX_PAYLOAD    = 8,
    parameter int         TIMEOUT_CLOCKS = 1000,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    localparam int        LW             = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               byte_i,
    input  logic                     byte_valid_i,
    output logic [7:0]               cmd_opcode_o,
    output logic [LW-1:0]            cmd_len_o,
    output logic [8*MAX_PAYLOAD-1:0] cmd_payload_o,
    output logic                     cmd_valid_o,
    input  logic                     cmd_ready_i,
    output logic                     err_o,
    output logic [1:0]               err_code_o,
    output logic                     busy_o
);

    localparam int         TW          = $clog2(TIMEOUT_CLOCKS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLOCKS - 1);
    localparam logic [7:0] MAX_LEN     = 8'(MAX_PAYLOAD);
    localparam logic [1:0] ERR_LEN     = 2'd0;
`ifdef UART_CMD_CHECKSUM_EN
    localparam logic [1:0] ERR_CSUM    = 2'd1;
`endif
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    typedef enum logic [2:0] {
        S_SYNC,
        S_OPCODE,
        S_LEN,
        S_PAYLOAD,
`ifdef UART_CMD_CHECKSUM_EN
        S_CSUM,
`endif
        S_HOLD
    } state_t;

`ifdef UART_CMD_CHECKSUM_EN
    localparam state_t BODY_DONE = S_CSUM;
`else
    localparam state_t BODY_DONE = S_HOLD;
`endif

    state_t                        state_q, state_d;
    logic [7:0]                    opcode_q;
    logic [LW-1:0]                 len_q;
    logic [LW-1:0]                 idx_q;
    logic [MAX_PAYLOAD-1:0][7:0]   payload_q;
    logic [TW-1:0]                 tmo_q;
    logic                          frame_start, load_opcode, load_len, store_byte;
    logic                          err_d;
    logic [1:0]                    err_code_d;
    logic                          timed, tmo_expire;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]                    sum_q;
    logic [7:0]                    csum_total;
    assign csum_total = sum_q + byte_i;
`endif

    // Timeout only runs while a frame is partially received.
    always_comb begin
        timed = (state_q == S_OPCODE) || (state_q == S_LEN) || (state_q == S_PAYLOAD);
`ifdef UART_CMD_CHECKSUM_EN
        timed = timed || (state_q == S_CSUM);
`endif
        tmo_expire = timed && !byte_valid_i && (tmo_q == TMO_LAST);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        load_opcode = 1'b0;
        load_len    = 1'b0;
        store_byte  = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_o;
        case (state_q)
            S_SYNC: begin
                if (byte_valid_i && byte_i == SYNC_BYTE) begin
                    frame_start = 1'b1;
                    state_d     = S_OPCODE;
                end
            end
            S_OPCODE: begin
                if (byte_valid_i) begin
                    load_opcode = 1'b1;
                    state_d     = S_LEN;
                end
            end
            S_LEN: begin
                if (byte_valid_i) begin
                    if (byte_i > MAX_LEN) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = S_SYNC;
                    end else begin
                        load_len = 1'b1;
                        state_d  = (byte_i == 8'd0) ? BODY_DONE : S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (byte_valid_i) begin
                    store_byte = 1'b1;
                    if (idx_q == len_q - LW'(1)) begin
                        state_d = BODY_DONE;
                    end
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            S_CSUM: begin
                if (byte_valid_i) begin
                    if (csum_total == 8'd0) begin
                        state_d = S_HOLD;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CSUM;
                        state_d    = S_SYNC;
                    end
                end
            end
`endif
            S_HOLD: begin
                // A byte here is lost, but a same-cycle handshake still completes.
                if (byte_valid_i) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_OVERRUN;
                end
                if (cmd_ready_i) begin
                    state_d = S_SYNC;
                end
            end
            default: state_d = S_SYNC;
        endcase
        if (tmo_expire) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = S_SYNC;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            opcode_q  <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            payload_q <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            if (frame_start) begin
                opcode_q  <= '0;
                len_q     <= '0;
                idx_q     <= '0;
                payload_q <= '0;
`ifdef UART_CMD_CHECKSUM_EN
                sum_q     <= '0;
`endif
            end
            if (load_opcode) begin
                opcode_q <= byte_i;
            end
            if (load_len) begin
                len_q <= byte_i[LW-1:0];
            end
            if (store_byte) begin
                for (int k = 0; k < MAX_PAYLOAD; k++) begin
                    if (idx_q == LW'(k)) begin
                        payload_q[k] <= byte_i;
                    end
                end
                idx_q <= idx_q + LW'(1);
            end
`ifdef UART_CMD_CHECKSUM_EN
            if (load_opcode || load_len || store_byte) begin
                sum_q <= sum_q + byte_i;
            end
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else if (byte_valid_i || !timed || tmo_expire) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_o      <= 1'b0;
            err_code_o <= 2'd0;
        end else begin
            err_o      <= err_d;
            err_code_o <= err_code_d;
        end
    end

    assign cmd_valid_o   = (state_q == S_HOLD);
    assign busy_o        = (state_q != S_SYNC);
    assign cmd_opcode_o  = opcode_q;
    assign cmd_len_o     = len_q;
    assign cmd_payload_o = payload_q;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Bench for uart_cmd_framer: directed scenarios plus a randomized frame stream against a stream-level parser model.
module tb_uart_cmd_framer;
    localparam int         MP   = 8;
    localparam int         TO   = 20;
    localparam int         LW   = $clog2(MP + 1);
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef UART_CMD_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [7:0]      byte_i = '0;
    logic            byte_valid_i = 1'b0;
    logic [7:0]      cmd_opcode_o;
    logic [LW-1:0]   cmd_len_o;
    logic [8*MP-1:0] cmd_payload_o;
    logic            cmd_valid_o;
    logic            cmd_ready_i = 1'b1;
    logic            err_o;
    logic [1:0]      err_code_o;
    logic            busy_o;

    uart_cmd_framer #(.MAX_PAYLOAD(MP), .TIMEOUT_CLOCKS(TO), .SYNC_BYTE(SYNC)) dut (
        .clock(clock), .reset(reset), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
        .cmd_opcode_o(cmd_opcode_o), .cmd_len_o(cmd_len_o), .cmd_payload_o(cmd_payload_o),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .err_o(err_o),
        .err_code_o(err_code_o), .busy_o(busy_o)
    );

    always #5 clock = ~clock;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [7:0]      op;
        logic [LW-1:0]   len;
        logic [8*MP-1:0] pl;
    } cmd_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    cmd_t       got_cmd_q[$];
    logic [1:0] got_err_q[$];
    cmd_t       exp_cmd_q[$];
    logic [1:0] exp_err_q[$];

    always @(negedge clock) begin
        if (!reset) begin
            if (err_o) got_err_q.push_back(err_code_o);
            if (cmd_valid_o && cmd_ready_i) got_cmd_q.push_back('{cmd_opcode_o, cmd_len_o, cmd_payload_o});
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_i = b; byte_valid_i = 1'b1;
        @(posedge clock); #1;
        byte_valid_i = 1'b0; byte_i = '0;
    endtask

    task automatic send_all(input byte_q_t q);
        foreach (q[i]) send_byte(q[i]);
    endtask

    function automatic byte_q_t make_frame(input logic [7:0] op, input byte_q_t pl, input bit corrupt);
        byte_q_t    f;
        logic [7:0] s;
        f.push_back(SYNC); f.push_back(op); f.push_back(8'(pl.size()));
        s = op + 8'(pl.size());
        foreach (pl[k]) begin f.push_back(pl[k]); s = s + pl[k]; end
        if (CSUM_EN) f.push_back(8'h00 - s + (corrupt ? 8'h01 : 8'h00));
        return f;
    endfunction

    // Stream-level reference: walks the whole byte stream by frame layout rules.
    function automatic void ref_parse(input byte_q_t s);
        int i = 0, n = s.size(), ln, need;
        logic [7:0] sum;
        logic [8*MP-1:0] pl;
        exp_cmd_q.delete(); exp_err_q.delete();
        while (i < n) begin
            if (s[i] != SYNC) begin i++; continue; end
            if (i + 2 >= n) break;
            ln = int'(s[i+2]);
            if (ln > MP) begin exp_err_q.push_back(2'd0); i += 3; continue; end
            need = 3 + ln + (CSUM_EN ? 1 : 0);
            if (i + need > n) break;
            pl = '0; sum = s[i+1] + s[i+2];
            for (int k = 0; k < ln; k++) begin pl[8*k +: 8] = s[i+3+k]; sum = sum + s[i+3+k]; end
            if (CSUM_EN) begin
                sum = sum + s[i+3+ln];
                if (sum != 8'h00) begin exp_err_q.push_back(2'd1); i += need; continue; end
            end
            exp_cmd_q.push_back('{s[i+1], LW'(ln), pl});
            i += need;
        end
    endfunction

    task automatic test_reset();
        idle(2);
        n_cmp++; if (cmd_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset.valid got=%0b exp=0", cmd_valid_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset.busy got=%0b exp=0", busy_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset.err got=%0b exp=0", err_o); end
        n_cmp++; if (err_code_o !== 2'd0) begin n_fail++; $display("FAIL reset.err_code got=%0d exp=0", err_code_o); end
        n_cmp++; if (cmd_opcode_o !== 8'h00) begin n_fail++; $display("FAIL reset.opcode got=%h exp=00", cmd_opcode_o); end
        n_cmp++; if (cmd_len_o !== '0) begin n_fail++; $display("FAIL reset.len got=%0d exp=0", cmd_len_o); end
        n_cmp++; if (cmd_payload_o !== '0) begin n_fail++; $display("FAIL reset.payload got=%h exp=0", cmd_payload_o); end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_valid_frame();
        byte_q_t pl = '{8'h11, 8'h22};
        byte_q_t f  = make_frame(8'h10, pl, 1'b0);
        send_byte(f[0]);
        n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL valid.busy_after_sync got=%0b exp=1", busy_o); end
        for (int i = 1; i < f.size(); i++) send_byte(f[i]);
        n_cmp++; if (cmd_valid_o !== 1'b1) begin n_fail++; $display("FAIL valid.valid got=%0b exp=1", cmd_valid_o); end
        n_cmp++; if (cmd_opcode_o !== 8'h10) begin n_fail++; $display("FAIL valid.opcode got=%h exp=10", cmd_opcode_o); end
        n_cmp++; if (cmd_len_o !== LW'(2)) begin n_fail++; $display("FAIL valid.len got=%0d exp=2", cmd_len_o); end
        n_cmp++; if (cmd_payload_o !== 64'h2211) begin n_fail++; $display("FAIL valid.payload got=%h exp=2211", cmd_payload_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL valid.err got=%0b exp=0", err_o); end
        idle(1);
        n_cmp++; if (cmd_valid_o !== 1'b0) begin n_fail++; $display("FAIL valid.valid_drop got=%0b exp=0", cmd_valid_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL valid.busy_after got=%0b exp=0", busy_o); end
    endtask

    task automatic test_checksum();
        byte_q_t pl = '{8'h11, 8'h22};
        byte_q_t f  = make_frame(8'h10, pl, 1'b1);
`ifdef UART_CMD_CHECKSUM_EN
        send_all(f);
        n_cmp++; if (f[5] !== 8'hBC) begin n_fail++; $display("FAIL csum.frame_byte got=%h exp=bc", f[5]); end
        n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL csum.err got=%0b exp=1", err_o); end
        n_cmp++; if (err_code_o !== 2'd1) begin n_fail++; $display("FAIL csum.code got=%0d exp=1", err_code_o); end
        n_cmp++; if (cmd_valid_o !== 1'b0) begin n_fail++; $display("FAIL csum.valid got=%0b exp=0", cmd_valid_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL csum.busy got=%0b exp=0", busy_o); end
`else
        send_all(f);
        n_cmp++; if (cmd_valid_o !== 1'b1) begin n_fail++; $display("FAIL nocsum.valid got=%0b exp=1", cmd_valid_o); end
        n_cmp++; if (cmd_payload_o !== 64'h2211) begin n_fail++; $display("FAIL nocsum.payload got=%h exp=2211", cmd_payload_o); end
        idle(1);
        send_byte(8'hBC);
        n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL nocsum.err got=%0b exp=0", err_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL nocsum.busy got=%0b exp=0", busy_o); end
`endif
        idle(1);
        n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL csum.err_one_cycle got=%0b exp=0", err_o); end
    endtask

    task automatic test_len_overflow();
        byte_q_t empty_pl;
        byte_q_t f;
        send_byte(SYNC); send_byte(8'h33); send_byte(8'h09);
        n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL len.err got=%0b exp=1", err_o); end
        n_cmp++; if (err_code_o !== 2'd0) begin n_fail++; $display("FAIL len.code got=%0d exp=0", err_code_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL len.busy got=%0b exp=0", busy_o); end
        f = make_frame(8'h33, empty_pl, 1'b0);
        send_all(f);
        n_cmp++; if (cmd_valid_o !== 1'b1) begin n_fail++; $display("FAIL len0.valid got=%0b exp=1", cmd_valid_o); end
        n_cmp++; if (cmd_opcode_o !== 8'h33) begin n_fail++; $display("FAIL len0.opcode got=%h exp=33", cmd_opcode_o); end
        n_cmp++; if (cmd_len_o !== '0) begin n_fail++; $display("FAIL len0.len got=%0d exp=0", cmd_len_o); end
        n_cmp++; if (cmd_payload_o !== '0) begin n_fail++; $display("FAIL len0.payload got=%h exp=0", cmd_payload_o); end
        idle(1);
    endtask

    task automatic test_timeout();
        int k = 0;
        send_byte(SYNC); send_byte(8'h10);
        while (err_o !== 1'b1 && k < 3 * TO) begin @(posedge clock); #1; k++; end
        n_cmp++; if (k != TO) begin n_fail++; $display("FAIL timeout.delay got=%0d exp=%0d cycles after strobe+1", k, TO); end
        n_cmp++; if (err_code_o !== 2'd2) begin n_fail++; $display("FAIL timeout.code got=%0d exp=2", err_code_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL timeout.busy got=%0b exp=0", busy_o); end
        idle(1);
        n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL timeout.one_cycle got=%0b exp=0", err_o); end
        send_byte(SYNC); send_byte(8'h10);
        idle(TO - 1);
        send_byte(8'h00);
        n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL expiry_byte.err got=%0b exp=0", err_o); end
        n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL expiry_byte.busy got=%0b exp=1", busy_o); end
        if (CSUM_EN) send_byte(8'hF0);
        n_cmp++; if (cmd_valid_o !== 1'b1) begin n_fail++; $display("FAIL expiry_byte.valid got=%0b exp=1", cmd_valid_o); end
        n_cmp++; if (cmd_opcode_o !== 8'h10) begin n_fail++; $display("FAIL expiry_byte.opcode got=%h exp=10", cmd_opcode_o); end
        idle(1);
        n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL expiry_byte.late_err got=%0b exp=0", err_o); end
    endtask

    task automatic test_overrun();
        byte_q_t pl = '{8'h99};
        byte_q_t empty_pl;
        got_cmd_q.delete();
        cmd_ready_i = 1'b0;
        send_all(make_frame(8'h42, pl, 1'b0));
        send_byte(8'h55);
        n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL overrun.err got=%0b exp=1", err_o); end
        n_cmp++; if (err_code_o !== 2'd3) begin n_fail++; $display("FAIL overrun.code got=%0d exp=3", err_code_o); end
        idle(2);
        n_cmp++; if (cmd_valid_o !== 1'b1) begin n_fail++; $display("FAIL overrun.held got=%0b exp=1", cmd_valid_o); end
        n_cmp++; if (cmd_payload_o !== 64'h99 || cmd_opcode_o !== 8'h42 || cmd_len_o !== LW'(1)) begin
            n_fail++; $display("FAIL overrun.cmd got=%h/%0d/%h exp=42/1/99", cmd_opcode_o, cmd_len_o, cmd_payload_o); end
        cmd_ready_i = 1'b1;
        idle(1);
        cmd_ready_i = 1'b0;
        n_cmp++; if (cmd_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL overrun.release got=%0b/%0b exp=0/0", cmd_valid_o, busy_o); end
        send_all(make_frame(8'h43, empty_pl, 1'b0));
        cmd_ready_i = 1'b1;
        send_byte(8'h55);
        n_cmp++; if (err_o !== 1'b1 || err_code_o !== 2'd3) begin n_fail++; $display("FAIL overrun_ready.err got=%0b/%0d exp=1/3", err_o, err_code_o); end
        n_cmp++; if (cmd_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL overrun_ready.state got=%0b/%0b exp=0/0", cmd_valid_o, busy_o); end
        idle(2);
        n_cmp++; if (got_cmd_q.size() != 2) begin n_fail++; $display("FAIL overrun.transfers got=%0d exp=2", got_cmd_q.size()); end
    endtask

    task automatic test_reset_midframe();
        byte_q_t pl = '{8'h7E};
        send_byte(SYNC); send_byte(8'h20);
        n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL midreset.busy_before got=%0b exp=1", busy_o); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (busy_o !== 1'b0 || cmd_opcode_o !== 8'h00 || err_code_o !== 2'd0 || cmd_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL midreset.outputs got=%0b/%h/%0d/%0b exp=0/00/0/0", busy_o, cmd_opcode_o, err_code_o, cmd_valid_o); end
        @(posedge clock); #1;
        reset = 1'b0;
        send_all(make_frame(8'h20, pl, 1'b0));
        n_cmp++; if (cmd_valid_o !== 1'b1) begin n_fail++; $display("FAIL midreset.valid got=%0b exp=1", cmd_valid_o); end
        n_cmp++; if (cmd_payload_o !== 64'h7E || cmd_opcode_o !== 8'h20) begin n_fail++; $display("FAIL midreset.cmd got=%h/%h exp=20/7e", cmd_opcode_o, cmd_payload_o); end
        idle(1);
    endtask

    task automatic test_random_stream();
        byte_q_t s, pl, f;
        int r, n;
        for (int fr = 0; fr < 40; fr++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                logic [7:0] b = 8'($urandom);
                s.push_back(b == SYNC ? 8'h00 : b);
            end
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                s.push_back(SYNC); s.push_back(8'($urandom)); s.push_back(8'($urandom_range(MP + 1, 255)));
            end else begin
                pl.delete();
                n = int'($urandom_range(0, MP));
                for (int j = 0; j < n; j++) pl.push_back(8'($urandom));
                f = make_frame(8'($urandom), pl, r < 4);
                foreach (f[j]) s.push_back(f[j]);
            end
        end
        ref_parse(s);
        got_cmd_q.delete(); got_err_q.delete();
        cmd_ready_i = 1'b1;
        foreach (s[i]) begin send_byte(s[i]); idle(int'($urandom_range(1, 3))); end
        idle(4);
        n_cmp++; if (got_cmd_q.size() != exp_cmd_q.size()) begin n_fail++; $display("FAIL random.cmd_count got=%0d exp=%0d", got_cmd_q.size(), exp_cmd_q.size()); end
        n_cmp++; if (got_err_q.size() != exp_err_q.size()) begin n_fail++; $display("FAIL random.err_count got=%0d exp=%0d", got_err_q.size(), exp_err_q.size()); end
        for (int i = 0; i < got_cmd_q.size() && i < exp_cmd_q.size(); i++) begin
            n_cmp++;
            if (got_cmd_q[i].op !== exp_cmd_q[i].op || got_cmd_q[i].len !== exp_cmd_q[i].len || got_cmd_q[i].pl !== exp_cmd_q[i].pl) begin
                n_fail++; $display("FAIL random.cmd[%0d] got=%h/%0d/%h exp=%h/%0d/%h", i, got_cmd_q[i].op, got_cmd_q[i].len, got_cmd_q[i].pl,
                                   exp_cmd_q[i].op, exp_cmd_q[i].len, exp_cmd_q[i].pl); end
        end
        for (int i = 0; i < got_err_q.size() && i < exp_err_q.size(); i++) begin
            n_cmp++;
            if (got_err_q[i] !== exp_err_q[i]) begin n_fail++; $display("FAIL random.err[%0d] got=%0d exp=%0d", i, got_err_q[i], exp_err_q[i]); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_valid_frame();
        test_checksum();
        test_len_overflow();
        test_timeout();
        test_overrun();
        test_reset_midframe();
        test_random_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
